// File: rtl/fc_pkg.sv
// Shared constants for the fast-control command scheduler: command bit
// positions, field widths and a saturating counter helper.
package fc_pkg;

    localparam int FC_BCR          = 0;
    localparam int FC_L1A          = 1;
    localparam int FC_LINK_RESET   = 2;
    localparam int FC_BUFFER_CLEAR = 3;
    localparam int FC_CMD_W        = 4;
    localparam int BX_W            = 12;
    localparam int CNT_W           = 16;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (&value) ? value : value + CNT_W'(1);
    endfunction

endpackage

// File: rtl/fc_token_bucket.sv
// Token bucket limiting L1A bursts: one token per issued L1A, one token
// regained every REFILL_BX cycles, capped at BURST_MAX.
module fc_token_bucket #(
    parameter int BURST_MAX = 8,
    parameter int REFILL_BX = 40,
    parameter int TOK_W     = 4
) (
    input  logic             clk_bx,
    input  logic             reset_n,
    input  logic             consume,
    output logic             available,
    output logic [TOK_W-1:0] tokens
);

    localparam int RW = (REFILL_BX > 1) ? $clog2(REFILL_BX) : 1;

    logic [RW-1:0]    refill_cnt_reg;
    logic [TOK_W-1:0] tokens_reg;
    logic [TOK_W-1:0] tokens_next;
    logic             refill_wrap;

    assign refill_wrap = (refill_cnt_reg == RW'(REFILL_BX - 1));
    assign available   = (tokens_reg != '0);
    assign tokens      = tokens_reg;

    // A consume and a refill in the same cycle cancel out.
    always_comb begin
        tokens_next = tokens_reg;
        if (consume && !refill_wrap) begin
            tokens_next = tokens_reg - TOK_W'(1);
        end else if (refill_wrap && !consume && (tokens_reg < TOK_W'(BURST_MAX))) begin
            tokens_next = tokens_reg + TOK_W'(1);
        end
    end

    always_ff @(posedge clk_bx or negedge reset_n) begin
        if (!reset_n) begin
            refill_cnt_reg <= '0;
            tokens_reg     <= TOK_W'(BURST_MAX);
        end else begin
            refill_cnt_reg <= refill_wrap ? '0 : refill_cnt_reg + RW'(1);
            tokens_reg     <= tokens_next;
        end
    end

endmodule

// File: rtl/fc_cmd_scheduler.sv
// Fast-control command scheduler: orbit BX counter with BCR, L1A trigger rules,
// buffer-clear holdoff and slot-aligned link resets, one command field per BX.
module fc_cmd_scheduler
    import fc_pkg::*;
#(
    parameter int              MIN_SPACING   = 4,
    parameter int              BURST_MAX     = 8,
    parameter int              REFILL_BX     = 40,
    parameter int              CLEAR_HOLDOFF = 16,
    parameter logic [BX_W-1:0] LR_SLOT       = 12'd8
) (
    input  logic                clk_bx,
    input  logic                reset_n,
    input  logic [BX_W-1:0]     orb_length,
    input  logic                enable,
    input  logic [3:0]          req_l1a,
    input  logic                req_link_reset,
    input  logic                req_buffer_clear,
    input  logic                clr_counters,
    output logic [FC_CMD_W-1:0] fc_cmd,
    output logic [BX_W-1:0]     bx_pos,
    output logic [3:0]          tokens,
    output logic                lr_pending,
    output logic [CNT_W-1:0]    l1a_issued_cnt,
    output logic [CNT_W-1:0]    l1a_dropped_cnt
);

    localparam int SP_W = (MIN_SPACING > 1) ? $clog2(MIN_SPACING) : 1;
    localparam int HO_W = (CLEAR_HOLDOFF > 0) ? $clog2(CLEAR_HOLDOFF + 1) : 1;

    logic [BX_W-1:0]     bx_reg;
    logic [SP_W-1:0]     spacing_reg;
    logic [HO_W-1:0]     holdoff_reg;
    logic                clr_pend_reg;
    logic                lr_pend_reg;

    logic [BX_W-1:0]     eff_len;
    logic [BX_W-1:0]     lr_slot_bx;
    logic                bx_wrap;
    logic                l1a_req;
    logic                l1a_issue;
    logic                l1a_drop;
    logic                clr_issue;
    logic                lr_issue;
    logic                tok_avail;
    logic [3:0]          tok_count;
    logic [FC_CMD_W-1:0] cmd_next;

    fc_token_bucket #(
        .BURST_MAX (BURST_MAX),
        .REFILL_BX (REFILL_BX),
        .TOK_W     (4)
    ) u_bucket (
        .clk_bx    (clk_bx),
        .reset_n   (reset_n),
        .consume   (l1a_issue),
        .available (tok_avail),
        .tokens    (tok_count)
    );

    assign eff_len    = (orb_length < BX_W'(2)) ? BX_W'(2) : orb_length;
    assign bx_wrap    = (bx_reg >= eff_len - BX_W'(1));
    // A slot beyond the orbit would never be reached, so fall back to BX 0.
    assign lr_slot_bx = (LR_SLOT >= eff_len) ? '0 : LR_SLOT;

    assign l1a_req    = enable && (|req_l1a);
    assign clr_issue  = enable && clr_pend_reg;
    assign lr_issue   = enable && lr_pend_reg && (bx_reg == lr_slot_bx);
    assign l1a_issue  = l1a_req && (spacing_reg == '0) && tok_avail &&
                        (holdoff_reg == '0) && !clr_issue;
    assign l1a_drop   = l1a_req && !l1a_issue;
    assign lr_pending = lr_pend_reg;

    always_comb begin
        cmd_next                  = '0;
        cmd_next[FC_BCR]          = (bx_reg == '0);
        cmd_next[FC_L1A]          = l1a_issue;
        cmd_next[FC_LINK_RESET]   = lr_issue;
        cmd_next[FC_BUFFER_CLEAR] = clr_issue;
    end

    always_ff @(posedge clk_bx or negedge reset_n) begin
        if (!reset_n) begin
            bx_reg          <= '0;
            spacing_reg     <= '0;
            holdoff_reg     <= '0;
            clr_pend_reg    <= 1'b0;
            lr_pend_reg     <= 1'b0;
            fc_cmd          <= '0;
            bx_pos          <= '0;
            tokens          <= '0;
            l1a_issued_cnt  <= '0;
            l1a_dropped_cnt <= '0;
        end else begin
            bx_reg <= bx_wrap ? '0 : bx_reg + BX_W'(1);
            fc_cmd <= cmd_next;
            bx_pos <= bx_reg;
            tokens <= tok_count;

            if (l1a_issue) begin
                spacing_reg <= SP_W'(MIN_SPACING - 1);
            end else if (spacing_reg != '0) begin
                spacing_reg <= spacing_reg - SP_W'(1);
            end

            if (clr_issue) begin
                holdoff_reg <= HO_W'(CLEAR_HOLDOFF);
            end else if (holdoff_reg != '0) begin
                holdoff_reg <= holdoff_reg - HO_W'(1);
            end

            // Pending flags only survive while enabled; a fresh request re-arms.
            clr_pend_reg <= enable && req_buffer_clear;
            lr_pend_reg  <= enable && (req_link_reset || (lr_pend_reg && !lr_issue));

            if (clr_counters) begin
                l1a_issued_cnt  <= '0;
                l1a_dropped_cnt <= '0;
            end else begin
                if (l1a_issue) l1a_issued_cnt  <= sat_inc(l1a_issued_cnt);
                if (l1a_drop)  l1a_dropped_cnt <= sat_inc(l1a_dropped_cnt);
            end
        end
    end

endmodule
